kronos_id: RTL and testbench



---
 rtl/kronos_types.sv | 51 +++++
 rtl/kronos_RF.sv | 71 +++++++
 rtl/kronos_id.sv | 184 ++++++++++++++++++
 tb/tb_kronos_id.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
`default_nettype none
// ============================================================================
// Module      : kronos_types (package)
// Description : Shared types and constants for the Kronos RV32I pipeline.
//               pipeIFID_t  - fetch -> decode bundle {pc, ir}
//               pipeIDEX_t  - decode -> execute bundle
//               Opcode constants for the supported major opcodes and the
//               4-bit ALU operation encoding {bit30-class, funct3}.
// Revision    : 1.0 - initial release
// ============================================================================
package kronos_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  aluop;
        logic        regwr_alu;
        logic        branch;
        logic [31:0] addr;
    } pipeIDEX_t;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // ALU operations: {ir[30] class bit, funct3}
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/kronos_RF.sv
`default_nettype none
// ============================================================================
// Module      : kronos_RF
// Description : 32x32 integer register file, two combinational read ports,
//               one write port, with same-cycle write-through bypass and a
//               hard-wired zero for x0.
// Ports       : clk, rstz        - clock, synchronous active-low reset
//               rs1_sel/rs1_data - read port 1
//               rs2_sel/rs2_data - read port 2
//               regwr_en/sel/data- write-back port from execute
// Revision    : 1.0 - initial release
// ============================================================================
module kronos_RF #(
    parameter bit RF_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [4:0]  rs1_sel,
    input  logic [4:0]  rs2_sel,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [31:0] regwr_data,
    input  logic [4:0]  regwr_sel,
    input  logic        regwr_en
);

    logic [31:0] regs [32];
    logic        wr_en;

    // Writes are blocked while reset is asserted so that the file is left
    // untouched by anything on the write-back port during reset.
    assign wr_en = regwr_en & (regwr_sel != 5'd0) & rstz;

    if (RF_RESET) begin : g_rf_reset
        always_ff @(posedge clk) begin
            if (!rstz) begin
                for (int i = 0; i < 32; i++) begin
                    regs[i] <= '0;
                end
            end else if (wr_en) begin
                regs[regwr_sel] <= regwr_data;
            end
        end
    end else begin : g_rf_noreset
        always_ff @(posedge clk) begin
            if (wr_en) begin
                regs[regwr_sel] <= regwr_data;
            end
        end
    end

    // x0 is forced to zero, which also keeps a write to x0 from bypassing.
    always_comb begin
        rs1_data = '0;
        if (rs1_sel != 5'd0) begin
            if (regwr_en && (regwr_sel == rs1_sel)) rs1_data = regwr_data;
            else                                    rs1_data = regs[rs1_sel];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_sel != 5'd0) begin
            if (regwr_en && (regwr_sel == rs2_sel)) rs2_data = regwr_data;
            else                                    rs2_data = regs[rs2_sel];
        end
    end

endmodule

`default_nettype wire

// File: rtl/kronos_id.sv
`default_nettype none
// ============================================================================
// Module      : kronos_id
// Description : RV32I instruction decode stage. Accepts {pc, ir} from fetch,
//               reads operands from the register file (with write-back
//               bypass), decodes into a registered pipeIDEX_t bundle and
//               offers it to execute over a valid/ready handshake. Stalls
//               one bubble on a RAW hazard against the instruction held in
//               the decode register; an execute redirect flushes it.
// Ports       : clk, rstz              - clock, synchronous active-low reset
//               fetch/fetch_vld/rdy    - fetch handshake
//               decode/decode_vld/rdy  - execute handshake
//               regwr_data/sel/en      - write-back from execute
//               branch                 - execute redirect (flush)
// Revision    : 1.0 - initial release
// ============================================================================
module kronos_id
    import kronos_types::*;
#(
    parameter bit RF_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rstz,
    input  pipeIFID_t   fetch,
    input  logic        fetch_vld,
    output logic        fetch_rdy,
    output pipeIDEX_t   decode,
    output logic        decode_vld,
    input  logic        decode_rdy,
    input  logic [31:0] regwr_data,
    input  logic [4:0]  regwr_sel,
    input  logic        regwr_en,
    input  logic        branch
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = fetch.ir[6:0];
    assign funct3 = fetch.ir[14:12];
    assign rs1    = fetch.ir[19:15];
    assign rs2    = fetch.ir[24:20];
    assign imm_i  = {{20{fetch.ir[31]}}, fetch.ir[31:20]};
    assign imm_u  = {fetch.ir[31:12], 12'h000};
    assign imm_j  = {{12{fetch.ir[31]}}, fetch.ir[19:12], fetch.ir[20],
                     fetch.ir[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    kronos_RF #(
        .RF_RESET   (RF_RESET)
    ) u_rf (
        .clk        (clk),
        .rstz       (rstz),
        .rs1_sel    (rs1),
        .rs2_sel    (rs2),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .regwr_data (regwr_data),
        .regwr_sel  (regwr_sel),
        .regwr_en   (regwr_en)
    );

    // ------------------------------------------------------------------
    // RAW hazard against the instruction sitting in the decode register.
    // Only source fields that the incoming opcode actually reads count.
    // ------------------------------------------------------------------
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rd_held;
    logic       stall;

    assign uses_rs1 = (opcode == OP) || (opcode == OP_IMM) || (opcode == JALR);
    assign uses_rs2 = (opcode == OP);
    assign rd_held  = decode.ir[11:7];

    assign stall = decode_vld && decode.regwr_alu && (rd_held != 5'd0) &&
                   ((uses_rs1 && (rd_held == rs1)) ||
                    (uses_rs2 && (rd_held == rs2)));

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;
    logic handoff;

    assign fetch_rdy = rstz && (!decode_vld || decode_rdy) && !stall && !branch;
    assign accept    = fetch_vld && fetch_rdy;
    assign handoff   = decode_vld && decode_rdy;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    pipeIDEX_t dec_next;

    always_comb begin
        dec_next    = '0;
        dec_next.pc = fetch.pc;
        dec_next.ir = fetch.ir;
        case (opcode)
            OP: begin
                dec_next.op1       = rs1_data;
                dec_next.op2       = rs2_data;
                dec_next.aluop     = {fetch.ir[30], funct3};
                dec_next.regwr_alu = 1'b1;
            end
            OP_IMM: begin
                // ir[30] only selects SRAI; for the other immediates it is
                // part of the immediate value.
                dec_next.op1       = rs1_data;
                dec_next.op2       = imm_i;
                dec_next.aluop     = {(funct3 == 3'b101) && fetch.ir[30], funct3};
                dec_next.regwr_alu = 1'b1;
            end
            LUI: begin
                dec_next.op1       = '0;
                dec_next.op2       = imm_u;
                dec_next.aluop     = ADD;
                dec_next.regwr_alu = 1'b1;
            end
            AUIPC: begin
                dec_next.op1       = fetch.pc;
                dec_next.op2       = imm_u;
                dec_next.aluop     = ADD;
                dec_next.regwr_alu = 1'b1;
            end
            JAL: begin
                // Link value pc+4 is produced by the ALU; target goes in addr.
                dec_next.op1       = fetch.pc;
                dec_next.op2       = 32'd4;
                dec_next.aluop     = ADD;
                dec_next.regwr_alu = 1'b1;
                dec_next.branch    = 1'b1;
                dec_next.addr      = fetch.pc + imm_j;
            end
            JALR: begin
                dec_next.op1       = fetch.pc;
                dec_next.op2       = 32'd4;
                dec_next.aluop     = ADD;
                dec_next.regwr_alu = 1'b1;
                dec_next.branch    = 1'b1;
                dec_next.addr      = (rs1_data + imm_i) & ~32'd1;
            end
            default: begin
                // Unsupported opcode travels down the pipe as a no-op.
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decode register. Flush has priority over a new accept; the bundle is
    // only reloaded on accept, so it holds while execute back-pressures.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstz) begin
            decode_vld <= 1'b0;
            decode     <= '0;
        end else begin
            if (branch) begin
                decode_vld <= 1'b0;
            end else if (accept) begin
                decode     <= dec_next;
                decode_vld <= 1'b1;
            end else if (handoff) begin
                decode_vld <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kronos_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_kronos_id
// Description : Self-checking bench for kronos_id. Directed scenarios plus a
//               randomized run compared against a behavioural model built
//               from the RV32I decode rules and handshake rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kronos_id;
    import kronos_types::*;

    logic        clk = 1'b0;
    logic        rstz;
    pipeIFID_t   fetch;
    logic        fetch_vld;
    logic        fetch_rdy;
    pipeIDEX_t   decode;
    logic        decode_vld;
    logic        decode_rdy;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;
    logic        branch;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    kronos_id #(.RF_RESET(1'b1)) dut (
        .clk        (clk),
        .rstz       (rstz),
        .fetch      (fetch),
        .fetch_vld  (fetch_vld),
        .fetch_rdy  (fetch_rdy),
        .decode     (decode),
        .decode_vld (decode_vld),
        .decode_rdy (decode_rdy),
        .regwr_data (regwr_data),
        .regwr_sel  (regwr_sel),
        .regwr_en   (regwr_en),
        .branch     (branch)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] rf_read(logic [4:0] sel);
        return (sel == 5'd0) ? 32'd0 : mregs[sel];
    endfunction

    task automatic model_write(logic [4:0] sel, logic [31:0] data);
        if (sel != 5'd0) mregs[sel] = data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    function automatic pipeIDEX_t ref_decode(logic [31:0] pc, logic [31:0] ir);
        pipeIDEX_t   r;
        logic [31:0] a, b, iimm, jimm, uimm;
        logic [2:0]  f3;
        r    = '0;
        r.pc = pc;
        r.ir = ir;
        a    = rf_read(ir[19:15]);
        b    = rf_read(ir[24:20]);
        f3   = ir[14:12];
        iimm = 32'($signed(ir[31:20]));
        uimm = ir & 32'hFFFF_F000;
        jimm = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
        case (ir[6:0])
            7'h33: begin r.op1 = a; r.op2 = b; r.aluop = {ir[30], f3}; r.regwr_alu = 1; end
            7'h13: begin
                r.op1 = a; r.op2 = iimm; r.regwr_alu = 1;
                r.aluop = (f3 == 3'd5) ? {ir[30], f3} : {1'b0, f3};
            end
            7'h37: begin r.op1 = 0;  r.op2 = uimm; r.aluop = 4'd0; r.regwr_alu = 1; end
            7'h17: begin r.op1 = pc; r.op2 = uimm; r.aluop = 4'd0; r.regwr_alu = 1; end
            7'h6F: begin
                r.op1 = pc; r.op2 = 4; r.regwr_alu = 1; r.branch = 1; r.addr = pc + jimm;
            end
            7'h67: begin
                r.op1 = pc; r.op2 = 4; r.regwr_alu = 1; r.branch = 1;
                r.addr = (a + iimm) & 32'hFFFF_FFFE;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic model_stall(logic v, pipeIDEX_t d, logic [31:0] fir);
        logic [4:0] rdd;
        logic       u1, u2;
        rdd = d.ir[11:7];
        u1  = (fir[6:0] == 7'h33) || (fir[6:0] == 7'h13) || (fir[6:0] == 7'h67);
        u2  = (fir[6:0] == 7'h33);
        return v && d.regwr_alu && (rdd != 0) &&
               ((u1 && rdd == fir[19:15]) || (u2 && rdd == fir[24:20]));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        r   = $urandom;
        case ($urandom_range(0, 6))
            0: return {(r[0] ? 7'h20 : 7'h00), rs2, rs1, f3, rd, 7'h33};
            1: return {r[31:20], rs1, f3, rd, 7'h13};
            2: return {r[31:12], rd, 7'h37};
            3: return {r[31:12], rd, 7'h17};
            4: return {r[31:12], rd, 7'h6F};
            5: return {r[31:20], rs1, 3'b000, rd, 7'h67};
            default: return {r[31:7], 7'h7F};
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_vld  = 1'b0;
        regwr_en   = 1'b0;
        branch     = 1'b0;
        decode_rdy = 1'b1;
    endtask

    task automatic present(logic [31:0] pc, logic [31:0] ir);
        fetch.pc  = pc;
        fetch.ir  = ir;
        fetch_vld = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstz = 1'b0;
        idle();
        present(32'h0, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        tick(); tick();
        tests_run++;
        if (fetch_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_rdy: got %b expected 0", fetch_rdy); end
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_decode_vld: got %b expected 0", decode_vld); end
        tests_run++;
        if (decode !== '0) begin tests_failed++; $display("FAIL reset_decode: got %h expected 0", decode); end
        model_reset();
        fetch_vld = 1'b0;
        rstz = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        pipeIDEX_t e;
        present(32'h0, enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        e = ref_decode(32'h0, fetch.ir);
        #1;
        tests_run++;
        if (fetch_rdy !== 1'b1) begin tests_failed++; $display("FAIL addi_fetch_rdy: got %b expected 1", fetch_rdy); end
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode_vld !== 1'b1) begin tests_failed++; $display("FAIL addi_vld: got %b expected 1", decode_vld); end
        tests_run++;
        if (decode.op1 !== 32'd0 || decode.op2 !== 32'd5 || decode.aluop !== 4'd0 ||
            decode.regwr_alu !== 1'b1 || decode.branch !== 1'b0)
        begin tests_failed++; $display("FAIL addi_fields: got %h expected %h", decode, e); end
        tests_run++;
        if (decode !== e) begin tests_failed++; $display("FAIL addi_bundle: got %h expected %h", decode, e); end
        tick();
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL addi_handoff: got %b expected 0", decode_vld); end
    endtask

    task automatic test_back_to_back();
        pipeIDEX_t ea, eb, ec;
        decode_rdy = 1'b0;
        present(32'h10, enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));
        ea = ref_decode(32'h10, fetch.ir);
        tick();
        present(32'h14, enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'h13));
        eb = ref_decode(32'h14, fetch.ir);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (fetch_rdy !== 1'b0) begin tests_failed++; $display("FAIL bp_fetch_rdy[%0d]: got %b expected 0", i, fetch_rdy); end
            tests_run++;
            if (decode_vld !== 1'b1 || decode !== ea) begin tests_failed++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, decode, ea); end
            tick();
        end
        decode_rdy = 1'b1;
        #1;
        tests_run++;
        if (fetch_rdy !== 1'b1) begin tests_failed++; $display("FAIL bp_release_rdy: got %b expected 1", fetch_rdy); end
        tick();
        tests_run++;
        if (decode_vld !== 1'b1 || decode !== eb) begin tests_failed++; $display("FAIL bp_drain_b: got %h expected %h", decode, eb); end
        present(32'h18, enc_i(12'd3, 5'd0, 3'd0, 5'd3, 7'h13));
        ec = ref_decode(32'h18, fetch.ir);
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode_vld !== 1'b1 || decode !== ec) begin tests_failed++; $display("FAIL bp_drain_c: got %h expected %h", decode, ec); end
        tick();
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got %b expected 0", decode_vld); end
    endtask

    task automatic test_regfile();
        regwr_en = 1'b1; regwr_sel = 5'd3; regwr_data = 32'hDEAD_BEEF;
        model_write(5'd3, 32'hDEAD_BEEF);
        tick();
        regwr_en = 1'b0;
        present(32'h20, enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4));
        tick();
        tests_run++;
        if (decode.op1 !== 32'hDEAD_BEEF || decode.op2 !== 32'hDEAD_BEEF)
        begin tests_failed++; $display("FAIL rf_read: got op1=%h op2=%h expected deadbeef", decode.op1, decode.op2); end
        // same-cycle write and read of x3
        regwr_en = 1'b1; regwr_sel = 5'd3; regwr_data = 32'h1234_5678;
        model_write(5'd3, 32'h1234_5678);
        present(32'h24, enc_r(7'h20, 5'd3, 5'd3, 3'd0, 5'd6));
        tick();
        tests_run++;
        if (decode.op1 !== 32'h1234_5678 || decode.op2 !== 32'h1234_5678)
        begin tests_failed++; $display("FAIL rf_bypass: got op1=%h op2=%h expected 12345678", decode.op1, decode.op2); end
        tests_run++;
        if (decode.aluop !== 4'b1000) begin tests_failed++; $display("FAIL rf_sub_aluop: got %h expected 8", decode.aluop); end
        // write to x0 must neither bypass nor stick
        regwr_sel = 5'd0; regwr_data = 32'hFFFF_FFFF;
        present(32'h28, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7));
        tick();
        regwr_en = 1'b0;
        tests_run++;
        if (decode.op1 !== 32'd0 || decode.op2 !== 32'd0) begin tests_failed++; $display("FAIL rf_x0_bypass: got op1=%h op2=%h expected 0", decode.op1, decode.op2); end
        present(32'h2C, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8));
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode.op1 !== 32'd0) begin tests_failed++; $display("FAIL rf_x0_stored: got %h expected 0", decode.op1); end
        tick();
    endtask

    task automatic test_raw_stall();
        present(32'h30, enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13));
        tick();
        present(32'h34, enc_r(7'h00, 5'd2, 5'd2, 3'd0, 5'd5));
        #1;
        tests_run++;
        if (fetch_rdy !== 1'b0) begin tests_failed++; $display("FAIL raw_stall: got fetch_rdy=%b expected 0", fetch_rdy); end
        tick();
        // execute writes x2 back in the bubble cycle
        regwr_en = 1'b1; regwr_sel = 5'd2; regwr_data = 32'd7;
        model_write(5'd2, 32'd7);
        #1;
        tests_run++;
        if (fetch_rdy !== 1'b1 || decode_vld !== 1'b0)
        begin tests_failed++; $display("FAIL raw_one_bubble: got rdy=%b vld=%b expected rdy=1 vld=0", fetch_rdy, decode_vld); end
        tick();
        regwr_en = 1'b0; fetch_vld = 1'b0;
        tests_run++;
        if (decode_vld !== 1'b1 || decode.op1 !== 32'd7 || decode.op2 !== 32'd7 || decode.pc !== 32'h34)
        begin tests_failed++; $display("FAIL raw_bypass: got vld=%b op1=%h op2=%h pc=%h expected 1/7/7/34", decode_vld, decode.op1, decode.op2, decode.pc); end
        tick();
    endtask

    task automatic test_jumps();
        present(32'h40, enc_j(21'h100, 5'd1));
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode.addr !== 32'h140 || decode.op1 !== 32'h40 || decode.op2 !== 32'd4 ||
            decode.branch !== 1'b1 || decode.regwr_alu !== 1'b1)
        begin tests_failed++; $display("FAIL jal: got addr=%h op1=%h op2=%h br=%b expected 140/40/4/1", decode.addr, decode.op1, decode.op2, decode.branch); end
        tick();
        regwr_en = 1'b1; regwr_sel = 5'd1; regwr_data = 32'h200;
        model_write(5'd1, 32'h200);
        present(32'h44, enc_i(12'd3, 5'd1, 3'd0, 5'd0, 7'h67));
        tick();
        regwr_en = 1'b0; fetch_vld = 1'b0;
        tests_run++;
        if (decode.addr !== 32'h202 || decode.branch !== 1'b1 || decode.op1 !== 32'h44)
        begin tests_failed++; $display("FAIL jalr: got addr=%h br=%b op1=%h expected 202/1/44", decode.addr, decode.branch, decode.op1); end
        tick();
    endtask

    task automatic test_flush_illegal();
        pipeIDEX_t e;
        present(32'h50, enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13));
        tick();
        decode_rdy = 1'b0; branch = 1'b1;
        present(32'h54, enc_i(12'd2, 5'd0, 3'd0, 5'd10, 7'h13));
        #1;
        tests_run++;
        if (fetch_rdy !== 1'b0) begin tests_failed++; $display("FAIL flush_rdy: got %b expected 0", fetch_rdy); end
        tick();
        branch = 1'b0; fetch_vld = 1'b0;
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL flush_vld: got %b expected 0", decode_vld); end
        tick();
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL flush_no_accept: got %b expected 0", decode_vld); end
        decode_rdy = 1'b1;
        present(32'h58, 32'h0ABC_DE7F);
        e = ref_decode(32'h58, 32'h0ABC_DE7F);
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode_vld !== 1'b1 || decode.regwr_alu !== 1'b0 || decode.branch !== 1'b0 || decode !== e)
        begin tests_failed++; $display("FAIL illegal: got vld=%b %h expected %h", decode_vld, decode, e); end
        tick();
        tests_run++;
        if (decode_vld !== 1'b0) begin tests_failed++; $display("FAIL illegal_handoff: got %b expected 0", decode_vld); end
    endtask

    task automatic test_mid_reset();
        decode_rdy = 1'b0;
        present(32'h60, enc_i(12'd1, 5'd0, 3'd0, 5'd11, 7'h13));
        tick();
        fetch_vld = 1'b0;
        rstz = 1'b0;
        tick();
        tests_run++;
        if (decode_vld !== 1'b0 || fetch_rdy !== 1'b0)
        begin tests_failed++; $display("FAIL midreset: got vld=%b rdy=%b expected 0/0", decode_vld, fetch_rdy); end
        model_reset();
        rstz = 1'b1; decode_rdy = 1'b1;
        present(32'h64, enc_r(7'h00, 5'd1, 5'd3, 3'd0, 5'd4));
        tick();
        fetch_vld = 1'b0;
        tests_run++;
        if (decode.op1 !== 32'd0 || decode.op2 !== 32'd0)
        begin tests_failed++; $display("FAIL midreset_rf_clear: got op1=%h op2=%h expected 0", decode.op1, decode.op2); end
        tick();
    endtask

    task automatic test_random();
        logic      exp_vld, exp_rdy;
        pipeIDEX_t exp_dec;
        exp_vld = 1'b0;
        exp_dec = '0;
        for (int n = 0; n < 400; n++) begin
            fetch.pc   = $urandom & 32'hFFFF_FFFC;
            fetch.ir   = rand_instr();
            fetch_vld  = ($urandom_range(0, 3) != 0);
            decode_rdy = ($urandom_range(0, 3) != 0);
            branch     = ($urandom_range(0, 9) == 0);
            regwr_en   = $urandom_range(0, 1) == 1;
            regwr_sel  = 5'($urandom_range(0, 7));
            regwr_data = $urandom;
            if (regwr_en) model_write(regwr_sel, regwr_data);
            #1;
            exp_rdy = (!exp_vld || decode_rdy) && !model_stall(exp_vld, exp_dec, fetch.ir) && !branch;
            tests_run++;
            if (fetch_rdy !== exp_rdy) begin tests_failed++; $display("FAIL rand_fetch_rdy[%0d]: got %b expected %b", n, fetch_rdy, exp_rdy); end
            if (branch) exp_vld = 1'b0;
            else if (fetch_vld && exp_rdy) begin exp_dec = ref_decode(fetch.pc, fetch.ir); exp_vld = 1'b1; end
            else if (exp_vld && decode_rdy) exp_vld = 1'b0;
            tick();
            tests_run++;
            if (decode_vld !== exp_vld) begin tests_failed++; $display("FAIL rand_vld[%0d]: got %b expected %b", n, decode_vld, exp_vld); end
            if (exp_vld) begin
                tests_run++;
                if (decode !== exp_dec) begin tests_failed++; $display("FAIL rand_decode[%0d]: got %h expected %h", n, decode, exp_dec); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        rstz       = 1'b0;
        fetch      = '0;
        regwr_sel  = 5'd0;
        regwr_data = 32'd0;
        idle();
        test_reset();
        test_addi();
        test_back_to_back();
        test_regfile();
        test_raw_stall();
        test_jumps();
        test_flush_illegal();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
